// File: rtl/window_buffer_ctrl_param.sv
// window_buffer_ctrl_param: KxK window-buffer controller; optional abort input under WINBUF_CTRL_ABORT_EN
module window_buffer_ctrl_param #(
  parameter int WIN_SIZE   = 17,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int CNT_W      = 11,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
`ifdef WINBUF_CTRL_ABORT_EN
  input  logic             abort_i,
`endif
  input  logic             pix_valid_i,
  output logic             count_en_o,
  output logic             win_valid_o,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic             busy_o,
  output logic             progress_done_o
);
  if (WIN_SIZE < 2 || WIN_SIZE > IMG_W || WIN_SIZE > IMG_H ||
      (64'd1 << CNT_W) <= 64'(IMG_W) || (64'd1 << CNT_W) <= 64'(IMG_H) ||
      GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_param_err
    $error("window_buffer_ctrl_param: illegal parameter combination");
  end
  typedef enum logic [2:0] {IDLE, PRIME, FILL, OUT, GAP, FINISH, DONE} state_t;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIN_SIZE - 2);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(IMG_H - WIN_SIZE);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
  state_t     state, nxt;
  logic [3:0] gap_cnt;
  logic       abort, active, row_end;
`ifdef WINBUF_CTRL_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  assign active  = (state == FILL || state == OUT) && pix_valid_i;
  assign row_end = state == OUT && pix_valid_i && col_o == COL_LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start_i ? PRIME : IDLE;
      PRIME:   nxt = FILL;
      FILL:    nxt = (pix_valid_i && col_o == FILL_LAST) ? OUT : FILL;
      OUT:     nxt = !row_end ? OUT : row_o == ROW_LAST ? FINISH : GAP_CYCLES == 0 ? FILL : GAP;
      GAP:     nxt = gap_cnt == GAP_LAST ? FILL : GAP;
      FINISH:  nxt = DONE;
      DONE:    nxt = start_i ? DONE : IDLE;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  // Row/col clear on abort and in IDLE so every frame starts from (0,0)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      row_o   <= '0;
      col_o   <= '0;
      gap_cnt <= '0;
    end else if (abort || state == IDLE) begin
      row_o   <= '0;
      col_o   <= '0;
      gap_cnt <= '0;
    end else begin
      gap_cnt <= state == GAP ? gap_cnt + 4'd1 : 4'd0;
      if (active) col_o <= row_end ? '0 : col_o + 1'b1;
      if (row_end && row_o != ROW_LAST) row_o <= row_o + 1'b1;
    end
  always_comb begin
    count_en_o      = active;
    win_valid_o     = state == OUT && pix_valid_i;
    busy_o          = state != IDLE && state != DONE;
    progress_done_o = state == FINISH;
  end
endmodule

// File: tb/tb_window_buffer_ctrl_param.sv
// tb_window_buffer_ctrl_param: directed checks of the window-buffer controller (K=3, 8x6 image)
module tb_window_buffer_ctrl_param;
  localparam int K = 3, W = 8, H = 6, CW = 11;
  logic clk = 0, rst = 1, start = 0, start1 = 0, pix = 0, abort = 0;
  logic en, win, busy, done, en1, win1, busy1, done1;
  logic [CW-1:0] row, col, row1, col1;
  int nvec = 0, nmis = 0, wins;

  always #5 clk = ~clk;

  window_buffer_ctrl_param #(.WIN_SIZE(K), .IMG_W(W), .IMG_H(H), .CNT_W(CW), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start_i(start),
`ifdef WINBUF_CTRL_ABORT_EN
    .abort_i(abort),
`endif
    .pix_valid_i(pix), .count_en_o(en), .win_valid_o(win), .row_o(row), .col_o(col),
    .busy_o(busy), .progress_done_o(done));

  window_buffer_ctrl_param #(.WIN_SIZE(K), .IMG_W(W), .IMG_H(H), .CNT_W(CW), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1),
`ifdef WINBUF_CTRL_ABORT_EN
    .abort_i(abort),
`endif
    .pix_valid_i(pix), .count_en_o(en1), .win_valid_o(win1), .row_o(row1), .col_o(col1),
    .busy_o(busy1), .progress_done_o(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, {28'd0, en, win, busy, done}, 0);
    chk({tag, "_row"}, row, 0);
    chk({tag, "_col"}, col, 0);
  endtask

  // One frame with random stalls; windows must arrive in raster order and stalls must freeze row/col
  task automatic run_frame(input int pct, input bit hold, output int nwin);
    int k = 0;
    bit seen = 0, st;
    logic [CW-1:0] r0, c0;
    start = 0;
    tick;
    start = 1;
    for (int n = 0; n < 3000 && !seen; n++) begin
      pix = int'($urandom_range(99)) < pct;
      #1;
      seen = done;
      if (win) begin
        chk("win_row", row, k / (W - K + 1));
        chk("win_col", col, K - 1 + k % (W - K + 1));
        k++;
      end
      st = !pix;
      r0 = row;
      c0 = col;
      if (st) chk("stall_en", {en, win}, 0);
      @(posedge clk);
      #1;
      if (!hold) start = 0;
      if (st) begin
        chk("stall_row", row, r0);
        chk("stall_col", col, c0);
      end
    end
    chk("frame_done", seen, 1);
    nwin = k;
  endtask

  task automatic go_to(input int r, input int c);
    bit hit = 0;
    start = 0;
    tick;
    start = 1;
    pix = 1;
    for (int n = 0; n < 200 && !hit; n++) begin
      tick;
      start = 0;
      hit = busy && row == CW'(r) && col == CW'(c);
    end
    chk("reach_pos", hit, 1);
  endtask

  initial begin
    #1;
    chk_zero("reset0");
    tick;
    rst = 0;
    // Full frame, no stalls: PRIME, then per row 2 FILL, 6 OUT, 2 GAP
    start = 1;
    pix = 1;
    tick;
    start = 0;
    chk("prime_busy", {busy, en, win}, 3'b100);
    wins = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < W; c++) begin
        tick;
        chk("run_en", en, 1);
        chk("run_win", win, c >= K - 1);
        chk("run_row", row, r);
        chk("run_col", col, c);
        if (win) wins++;
      end
      if (r < 3) for (int g = 0; g < 2; g++) begin
        tick;
        chk("gap_en", {busy, en, win, done}, 4'b1000);
        chk("gap_row", row, r + 1);
        chk("gap_col", col, 0);
      end
    end
    chk("run_windows", wins, 24);
    tick;
    chk("finish", {busy, done, win}, 3'b110);
    tick;
    chk("done_state", {busy, done}, 0);
    tick;
    chk("idle_state", {busy, done}, 0);
    // Random stalls
    run_frame(50, 0, wins);
    chk("stall_windows", wins, 24);
    // No gap configuration: rows start every 8 valid cycles
    pix = 1;
    tick;
    start1 = 1;
    tick;
    start1 = 0;
    chk("g0_prime", {busy1, en1}, 2'b10);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++) begin
        tick;
        chk("g0_en", {en1, win1}, {1'b1, c >= K - 1});
        chk("g0_row", row1, r);
        chk("g0_col", col1, c);
      end
    tick;
    chk("g0_done", {done1, busy1}, 2'b11);
    tick;
    chk("g0_after", {done1, busy1}, 0);
    // start held high: one frame only
    run_frame(100, 1, wins);
    chk("hold_windows", wins, 24);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_stay", {busy, done}, 0);
    end
    start = 0;
    // Async reset mid-frame
    go_to(2, 5);
    #2 rst = 1;
    #1;
    chk_zero("async_rst");
    tick;
    chk_zero("rst_held");
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst", {busy, done}, 0);
    end
    run_frame(70, 0, wins);
    chk("rst_windows", wins, 24);
`ifdef WINBUF_CTRL_ABORT_EN
    go_to(1, 4);
    abort = 1;
    tick;
    abort = 0;
    chk_zero("abort");
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("post_abort", {busy, done}, 0);
    end
    run_frame(60, 0, wins);
    chk("abort_windows", wins, 24);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
